// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush, optional skid entry
// and a saturating stall counter.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              mValid, mValidNxt;
    logic [DATA_W-1:0] mData, mDataNxt;
    logic [CTRL_W-1:0] mCtrl, mCtrlNxt;
    logic              sValid, sValidNxt;
    logic [DATA_W-1:0] sData, sDataNxt;
    logic [CTRL_W-1:0] sCtrl, sCtrlNxt;
    logic [CNT_W-1:0]  stallCnt, stallCntNxt;
    logic              accept;
    logic              drain;

    // With a skid entry, in_ready depends only on state; without it, it sees out_ready.
    assign in_ready = (SKID != 0) ? !sValid : (!mValid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = mValid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid   <= 1'b0;
            mData    <= '0;
            mCtrl    <= '0;
            sValid   <= 1'b0;
            sData    <= '0;
            sCtrl    <= '0;
            stallCnt <= '0;
        end else begin
            mValid   <= mValidNxt;
            mData    <= mDataNxt;
            mCtrl    <= mCtrlNxt;
            sValid   <= sValidNxt;
            sData    <= sDataNxt;
            sCtrl    <= sCtrlNxt;
            stallCnt <= stallCntNxt;
        end
    end

    // Next-state: entry movement between input, skid and head.
    always_comb begin
        mValidNxt   = mValid;
        mDataNxt    = mData;
        mCtrlNxt    = mCtrl;
        sValidNxt   = sValid;
        sDataNxt    = sData;
        sCtrlNxt    = sCtrl;
        stallCntNxt = stallCnt;

        if (mValid && !out_ready && (stallCnt != CNT_MAX)) begin
            stallCntNxt = stallCnt + CNT_W'(1);
        end

        if (flush) begin
            mValidNxt = 1'b0;
            mCtrlNxt  = '0;
            sValidNxt = 1'b0;
        end else if (SKID != 0) begin
            if (!mValid || drain) begin
                if (sValid) begin
                    mValidNxt = 1'b1;
                    mDataNxt  = sData;
                    mCtrlNxt  = sCtrl;
                    sValidNxt = accept;
                    if (accept) begin
                        sDataNxt = in_data;
                        sCtrlNxt = in_ctrl;
                    end
                end else if (accept) begin
                    mValidNxt = 1'b1;
                    mDataNxt  = in_data;
                    mCtrlNxt  = in_ctrl;
                end else begin
                    mValidNxt = 1'b0;
                    mCtrlNxt  = '0;
                end
            end else if (accept) begin
                sValidNxt = 1'b1;
                sDataNxt  = in_data;
                sCtrlNxt  = in_ctrl;
            end
        end else begin
            if (accept) begin
                mValidNxt = 1'b1;
                mDataNxt  = in_data;
                mCtrlNxt  = in_ctrl;
            end else if (drain) begin
                mValidNxt = 1'b0;
                mCtrlNxt  = '0;
            end
        end
    end

    assign out_valid    = mValid;
    assign out_data     = mData;
    assign out_ctrl     = mCtrl;
    assign occupancy    = 2'(mValid) + 2'(sValid);
    assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg: a skid instance (4-bit counter)
// and a single-entry instance, both checked against queue-based reference models.
module tb_id_ex_pipe_reg;

    localparam int unsigned DW = 48;
    localparam int unsigned CW = 9;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;
    logic          outReady;

    logic          inReadyA, outValidA, inReadyB, outValidB;
    logic [DW-1:0] outDataA, outDataB;
    logic [CW-1:0] outCtrlA, outCtrlB;
    logic [1:0]    occA, occB;
    logic [3:0]    stallA;
    logic [15:0]   stallB;

    ent_t qa[$];
    ent_t qb[$];
    int   stA, stB;
    int   nChecks = 0;
    int   nFail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyA),
        .in_data(inData), .in_ctrl(inCtrl), .out_valid(outValidA), .out_ready(outReady),
        .out_data(outDataA), .out_ctrl(outCtrlA), .occupancy(occA), .stall_cycles(stallA)
    );

    id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyB),
        .in_data(inData), .in_ctrl(inCtrl), .out_valid(outValidB), .out_ready(outReady),
        .out_data(outDataB), .out_ctrl(outCtrlB), .occupancy(occB), .stall_cycles(stallB)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model view of in_ready: skid stage is ready while fewer than two entries are held;
    // the single-entry stage is ready when empty or when its head leaves this cycle.
    function automatic logic rdyA();
        return qa.size() < 2;
    endfunction
    function automatic logic rdyB();
        return (qb.size() == 0) || outReady;
    endfunction

    task automatic compareAll();
        ent_t e;
        chk("a_out_valid", 64'(outValidA), 64'(qa.size() > 0));
        chk("a_occupancy", 64'(occA), 64'(qa.size()));
        chk("a_stall", 64'(stallA), 64'(stA));
        if (qa.size() > 0) begin
            e = qa[0];
            chk("a_out_data", 64'(outDataA), 64'(e.d));
            chk("a_out_ctrl", 64'(outCtrlA), 64'(e.c));
        end else begin
            chk("a_bubble_ctrl", 64'(outCtrlA), 64'd0);
        end
        chk("b_out_valid", 64'(outValidB), 64'(qb.size() > 0));
        chk("b_occupancy", 64'(occB), 64'(qb.size()));
        chk("b_stall", 64'(stallB), 64'(stB));
        if (qb.size() > 0) begin
            e = qb[0];
            chk("b_out_data", 64'(outDataB), 64'(e.d));
            chk("b_out_ctrl", 64'(outCtrlB), 64'(e.c));
        end else begin
            chk("b_bubble_ctrl", 64'(outCtrlB), 64'd0);
        end
    endtask

    // One clock: check in_ready with inputs settled, advance models at the edge, check outputs.
    task automatic step();
        logic accA, accB, drA, drB;
        ent_t e;
        #1;
        chk("a_in_ready", 64'(inReadyA), 64'(rdyA()));
        chk("b_in_ready", 64'(inReadyB), 64'(rdyB()));
        accA = inValid && rdyA();
        accB = inValid && rdyB();
        drA  = (qa.size() > 0) && outReady;
        drB  = (qb.size() > 0) && outReady;
        e.d  = inData;
        e.c  = inCtrl;
        @(posedge clk);
        if ((qa.size() > 0) && !outReady && stA < 15) stA++;
        if ((qb.size() > 0) && !outReady && stB < 65535) stB++;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (drA) void'(qa.pop_front());
            if (accA) qa.push_back(e);
            if (drB) void'(qb.pop_front());
            if (accB) qb.push_back(e);
        end
        #1;
        compareAll();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
    task automatic doReset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_a_valid", 64'(outValidA), 64'd0);
        chk("rst_a_ctrl", 64'(outCtrlA), 64'd0);
        chk("rst_a_data", 64'(outDataA), 64'd0);
        chk("rst_a_occ", 64'(occA), 64'd0);
        chk("rst_a_stall", 64'(stallA), 64'd0);
        chk("rst_a_ready", 64'(inReadyA), 64'd1);
        chk("rst_b_valid", 64'(outValidB), 64'd0);
        chk("rst_b_occ", 64'(occB), 64'd0);
        chk("rst_b_stall", 64'(stallB), 64'd0);
        chk("rst_b_ready", 64'(inReadyB), 64'd1);
        qa.delete();
        qb.delete();
        stA = 0;
        stB = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        inValid  = v;
        inData   = d;
        inCtrl   = CW'(($urandom_range(1, 511)));
        outReady = r;
        flush    = f;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        stA = 0;
        stB = 0;
        #2;
        chk("init_a_valid", 64'(outValidA), 64'd0);
        chk("init_a_ready", 64'(inReadyA), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: one entry per cycle, one-cycle latency.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            step();
            chk("stream_data", 64'(outDataA), 64'(i));
            chk("stream_occ", 64'(occA), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Back-pressure: A to head, B to skid, C waits upstream.
        doReset();
        drive(1'b1, DW'('hA), 1'b0, 1'b0);
        step();
        drive(1'b1, DW'('hB), 1'b0, 1'b0);
        step();
        chk("bp_occ2", 64'(occA), 64'd2);
        chk("bp_ready_low", 64'(inReadyA), 64'd0);
        drive(1'b1, DW'('hC), 1'b0, 1'b0);
        step();
        step();
        chk("bp_head_a", 64'(outDataA), 64'hA);
        outReady = 1'b1;
        step();
        chk("bp_release_b", 64'(outDataA), 64'hB);
        step();
        chk("bp_release_c", 64'(outDataA), 64'hC);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();

        // Flush with two held entries and a concurrent input.
        drive(1'b1, DW'('h11), 1'b0, 1'b0);
        step();
        drive(1'b1, DW'('h22), 1'b0, 1'b0);
        step();
        drive(1'b1, DW'('h77), 1'b0, 1'b1);
        step();
        chk("flush_occ", 64'(occA), 64'd0);
        chk("flush_ctrl", 64'(outCtrlA), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();

        // Single-entry stage: in_ready follows out_ready in the same cycle.
        drive(1'b1, DW'('h55), 1'b0, 1'b0);
        step();
        drive(1'b1, DW'('h66), 1'b0, 1'b0);
        #1;
        chk("comb_ready_low", 64'(inReadyB), 64'd0);
        outReady = 1'b1;
        #1;
        chk("comb_ready_high", 64'(inReadyB), 64'd1);
        step();
        chk("comb_occ", 64'(occB), 64'd1);
        chk("comb_data", 64'(outDataB), 64'h66);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();

        // Saturation of the 4-bit counter, survives flush.
        doReset();
        drive(1'b1, DW'('h99), 1'b0, 1'b0);
        step();
        inValid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", 64'(stallA), 64'd15);
        step();
        chk("sat_hold", 64'(stallA), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("sat_after_flush", 64'(stallA), 64'd15);

        // Randomized traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'({$urandom(), $urandom()}),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
            if (i % 5 == 0) outReady = 1'b0;
            step();
            if (i == 300 && qa.size() == 2) begin
                drive(1'b0, '0, 1'b0, 1'b0);
                doReset();
            end
        end
        drive(1'b1, DW'('h123), 1'b0, 1'b0);
        step();
        step();
        doReset();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register with valid/ready flow control, flush (bubble insertion), an optional skid entry, and a saturating stall counter. It carries an arbitrary-width datapath payload (operands, store data) and control payload (ALU op, memory read/write, quarter select) from decode to execute. It replaces fixed-width, always-advancing stage latches so that hazards and multi-cycle units can stall or squash the stage.

## Interface
Parameters:
- DATA_W, 48, datapath payload width (e.g. readData0, readData1, DataIn concatenated)
- CTRL_W, 9, control payload width (e.g. ALUOp, ReadMem, WriteMem, quarter concatenated); all-zero encodes no-op
- SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  squash all held and incoming entries this cycle
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_data  in  DATA_W  datapath payload
- in_ctrl  in  CTRL_W  control payload
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes this cycle
- out_data  out  DATA_W  head datapath payload
- out_ctrl  out  CTRL_W  head control payload; zero whenever out_valid=0
- occupancy  out  2  entries held (0..1 if SKID=0, 0..2 if SKID=1)
- stall_cycles  out  CNT_W  saturating count of out_valid && !out_ready cycles

## Operation
- Storage: head entry M (drives out_*), skid entry S (present only if SKID=1).
- Accept = in_valid && in_ready; Drain = out_valid && out_ready.
- SKID=0: in_ready = !out_valid || out_ready (combinational). On Accept, M loads in_data/in_ctrl, out_valid←1. If no Accept and Drain, out_valid←0.
- SKID=1: in_ready = !S.valid (registered, no combinational path from out_ready).
  - M empty or Drain: M←S if S valid (S←incoming Accept if any, else S empty); else M←incoming Accept; else M empty.
  - M held (valid, no Drain) and Accept: S←incoming.
  - FIFO order always preserved; never an entry overwritten or duplicated.
- Bubble: whenever M is empty, out_ctrl=0 (register cleared, not masked); out_data holds last value (don't-care).
- flush=1: M and S emptied, out_ctrl←0 on next edge; an Accept in the same cycle is discarded; a Drain in the same cycle still completes downstream. flush overrides all other updates.
- occupancy = M.valid + S.valid.
- stall_cycles: +1 per cycle with out_valid && !out_ready; saturates at 2^CNT_W−1; cleared only by rst (not by flush).

## Timing
- Latency: input accepted at edge N appears on out_* after edge N (one cycle) when stage empty.
- Throughput: one entry per cycle sustained while out_ready=1, both SKID settings.
- SKID=1: after out_ready drops, one further input is absorbed into S; in_ready falls the following cycle.
- Reset (async assert, outputs immediately): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0, in_ready=1 (SKID=1) / 1 (SKID=0, since out_valid=0). Reset mid-transfer drops all entries; first accept allowed on first posedge after deassert.
- Simultaneous Accept+Drain with M full, S empty: M←incoming, occupancy stays 1.
- Simultaneous Accept+Drain with S full: impossible by construction (in_ready=0).

## Test plan
- Reset/idle: assert rst mid-run with occupancy=2 → out_valid=0, out_ctrl=0, stall_cycles=0 immediately; in_ready=1.
- Streaming: SKID=1, out_ready=1, push payloads 0x001..0x010 back-to-back → out_data 0x001..0x010 in order, one per cycle, one-cycle latency, occupancy=1 steady.
- Back-pressure: SKID=1, push A,B,C while out_ready=0 from cycle 1 → A in M, B in S, in_ready=0, C held upstream; release → A,B,C in order; stall_cycles equals out_ready=0 cycles with out_valid=1.
- Flush: occupancy=2 and in_valid=1 with flush=1 → next cycle occupancy=0, out_ctrl=0, incoming entry never appears at output.
- SKID=0 comb path: out_valid=1, toggle out_ready → in_ready follows same cycle; Accept+Drain keeps occupancy=1 with new payload.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles → stall_cycles=15, remains 15; flush does not clear it.
